// File: rtl/mux2_arb_if.sv
// ============================================================================
// Module      : mux2_arb_if
// Description : Request/grant/select bundle between the requesters, the
//               mux2_arb arbiter and the downstream consumer of the shared mux.
//               With MUX2_ARB_STATS_EN defined the bundle also carries the
//               grant statistics counters and their synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux2_arb_if
`ifdef MUX2_ARB_STATS_EN
    #(parameter int CNT_W = 16)
`endif
    ;

    // Requester side
    logic req_a;
    logic req_b;
    // Downstream consumer accepts the current beat
    logic ready;
    // Arbiter results
    logic gnt_a;
    logic gnt_b;
    logic sel;
    logic busy;
    logic xfer;

`ifdef MUX2_ARB_STATS_EN
    logic             stats_clr;
    logic [CNT_W-1:0] gcnt_a;
    logic [CNT_W-1:0] gcnt_b;
`endif

    // Arbiter view
    modport slave (
        input  req_a,
        input  req_b,
        input  ready,
`ifdef MUX2_ARB_STATS_EN
        input  stats_clr,
        output gcnt_a,
        output gcnt_b,
`endif
        output gnt_a,
        output gnt_b,
        output sel,
        output busy,
        output xfer
    );

    // Requester / consumer view
    modport master (
        output req_a,
        output req_b,
        output ready,
`ifdef MUX2_ARB_STATS_EN
        output stats_clr,
        input  gcnt_a,
        input  gcnt_b,
`endif
        input  gnt_a,
        input  gnt_b,
        input  sel,
        input  busy,
        input  xfer
    );

endinterface

`default_nettype wire

// File: rtl/mux2_arb.sv
// ============================================================================
// Module      : mux2_arb
// Description : Round-robin arbiter for a shared 2-to-1 mux. Grants one of
//               two requesters at a time, drives the mux select for the whole
//               tenure and bounds a tenure to HOLD_MAX beats while the other
//               requester waits. Optional grant statistics are enabled with
//               the MUX2_ARB_STATS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_arb #(
    parameter int HOLD_MAX = 4,   // beats per grant under contention, 1..255
    parameter int CNT_W    = 16   // width of the optional statistics counters
) (
    input  wire logic   clock,
    input  wire logic   reset_n,
    mux2_arb_if.slave   bus
);

    // Beat counter only has to reach HOLD_MAX-1 before it is cleared.
    localparam int              CW     = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0]   C_LAST = CW'(HOLD_MAX - 1);

    // Reject illegal configurations at elaboration.
    if (HOLD_MAX < 1 || HOLD_MAX > 255 || CNT_W < 1) begin : g_bad_param
        $error("mux2_arb: HOLD_MAX must be 1..255 and CNT_W at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_b_q, last_b_d;   // 1: B was served last
    logic            gnt_a_q, gnt_b_q, sel_q, busy_q;

    logic            xfer;
    logic            beat_limit;
    logic            entry_a;
    logic            entry_b;

    // A beat moves when the owner still requests and the consumer is ready.
    assign xfer       = ((gnt_a_q & bus.req_a) | (gnt_b_q & bus.req_b)) & bus.ready;
    // The HOLD_MAX-th beat of this tenure is moving this cycle.
    assign beat_limit = xfer && (cnt_q == C_LAST);

    assign entry_a = (state_d == GNT_A) && (state_q != GNT_A);
    assign entry_b = (state_d == GNT_B) && (state_q != GNT_B);

    // Next-state, beat counter and last-served bookkeeping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;

        case (state_q)
            IDLE: begin
                // On contention the requester not served last wins.
                if (bus.req_a && (!bus.req_b || last_b_q)) begin
                    state_d = GNT_A;
                end else if (bus.req_b) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                // A dropped request takes priority over the beat limit.
                if (!bus.req_a) begin
                    state_d = bus.req_b ? GNT_B : IDLE;
                end else if (beat_limit && bus.req_b) begin
                    state_d = GNT_B;
                end
            end
            GNT_B: begin
                if (!bus.req_b) begin
                    state_d = bus.req_a ? GNT_A : IDLE;
                end else if (beat_limit && bus.req_a) begin
                    state_d = GNT_A;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counter restarts on every ownership change and recycles at the
        // limit so a lone requester keeps its grant.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (beat_limit) begin
            cnt_d = '0;
        end else if (xfer) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (entry_a) begin
            last_b_d = 1'b0;
        end else if (entry_b) begin
            last_b_d = 1'b1;
        end
    end

    // State register and registered grant/select outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            gnt_a_q  <= (state_d == GNT_A);
            gnt_b_q  <= (state_d == GNT_B);
            sel_q    <= (state_d == GNT_B);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign bus.gnt_a = gnt_a_q;
    assign bus.gnt_b = gnt_b_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;
    assign bus.xfer  = xfer;

`ifdef MUX2_ARB_STATS_EN
    logic [CNT_W-1:0] gcnt_a_q;
    logic [CNT_W-1:0] gcnt_b_q;

    // Saturating grant-entry counters; a clear wins over a coincident entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gcnt_a_q <= '0;
            gcnt_b_q <= '0;
        end else if (bus.stats_clr) begin
            gcnt_a_q <= '0;
            gcnt_b_q <= '0;
        end else begin
            if (entry_a && (gcnt_a_q != '1)) begin
                gcnt_a_q <= gcnt_a_q + CNT_W'(1);
            end
            if (entry_b && (gcnt_b_q != '1)) begin
                gcnt_b_q <= gcnt_b_q + CNT_W'(1);
            end
        end
    end

    assign bus.gcnt_a = gcnt_a_q;
    assign bus.gcnt_b = gcnt_b_q;
`endif

endmodule

`default_nettype wire
